pipe_stage_gen: RTL and testbench
=================================

Name: pipe_stage_gen

Overview:
- Parametrised pipeline latch. It is the next generation of the fixed EX/MEM style stage registers.
- Carries an arbitrary-width payload through 1..4 register stages.
- Built-in behaviour: valid tracking, stall, flush/bubble insertion, data-memory request retirement on dhit, and a sticky halt.
- Instantiated between any two datapath stages (IF/ID, ID/EX, EX/MEM, MEM/WB) in place of hand-written latches.

Parameters:
- DATA_W, 32, payload width in bits (1..256).
- DEPTH, 1, number of register stages (1..4); latency in advances.
- RESET_VAL, '0, payload value loaded on reset and on bubble insertion.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- ihit  input  1  instruction fetch complete; global advance qualifier.
- dhit  input  1  data memory access complete.
- stall  input  1  hazard stall; hold all stages.
- flush  input  1  squash; stage 0 loads a bubble.
- valid_in  input  1  incoming slot holds a real instruction.
- data_in  input  DATA_W  incoming payload.
- dREN_in  input  1  data read request for this slot.
- dWEN_in  input  1  data write request for this slot.
- halt_in  input  1  halt instruction in this slot.
- valid_out  output  1  last stage holds a real instruction.
- data_out  output  DATA_W  last stage payload.
- dREN_out  output  1  outstanding read request of last stage.
- dWEN_out  output  1  outstanding write request of last stage.
- halt_out  output  1  sticky halt.

Behaviour:
- Every stage k holds {valid, data, dREN, dWEN, halt}.
- Reset (nRST low, asynchronous):
  - all valid=0, data=RESET_VAL, dREN=dWEN=0, halt=0.
  - Outputs follow the last stage immediately, so valid_out=0, data_out=RESET_VAL, dREN_out=dWEN_out=halt_out=0.
  - Reset mid-operation discards all contents with no partial retirement.
- advance = ihit & ~stall.
- On a CLK edge with advance=1:
  - stage k loads stage k-1 for k>=1.
  - stage 0 loads the inputs, or a bubble if flush=1.
  - Bubble = valid 0, data RESET_VAL, dREN/dWEN/halt 0.
- flush & ihit & stall:
  - stage 0 loads a bubble; stages 1..DEPTH-1 hold.
  - flush has priority over stall for stage 0 only.
- flush without ihit: no effect. The flush request must be held by the hazard unit until ihit.
- advance=0 and no flush: all stages hold.
- dhit=1 with advance=0:
  - last stage dREN and dWEN are cleared at the edge.
  - data, valid and halt are unchanged.
  - This prevents a re-issued memory request while the fetch is still pending.
- dhit=1 with advance=1: advance wins; the last stage loads stage DEPTH-2 (or the inputs if DEPTH=1) with unmodified request bits.
- valid_in=0: the slot is forced to a bubble regardless of data_in and request bits.
- halt_out:
  - set when the last stage holds halt=1 with valid=1.
  - once set, halt_out stays 1 until nRST, even if later flushed.
- Latency: an input accepted at advance n appears at the outputs after DEPTH advances; stalled cycles do not count.
- Outputs are purely registered, with no combinational path from inputs to outputs.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- When defined, add three outputs:
  - stall_cnt[31:0]: increments on every edge with ihit & stall.
  - bubble_cnt[31:0]: increments on every edge where the last stage loads valid=0.
  - retire_cnt[31:0]: increments on every advance that shifts out a valid last stage.
- All counters are zeroed by nRST, wrap modulo 2^32, and freeze once halt_out=1.
- When undefined: ports absent, no counter logic.

Test Plan:
- DEPTH=1, DATA_W=32: valid_in=1, data_in=32'hDEADBEEF, ihit pulse -> next edge valid_out=1, data_out=32'hDEADBEEF.
- DEPTH=3: inject 3 values 1,2,3 on consecutive ihit; hold stall=1 for 4 cycles after the second -> data_out sequence 1,2,3 delivered after exactly 3 advances each; outputs frozen during stall.
- DEPTH=1: dREN_in=1 accepted, then ihit=0, dhit=1 -> next edge dREN_out=0, data_out and valid_out unchanged; dhit with ihit=1 same cycle -> new slot loaded intact.
- flush=1, stall=1, ihit=1 with valid_in=1, DEPTH=2 -> stage 0 becomes a bubble, stage 1 holds; two advances later valid_out=0, data_out=RESET_VAL.
- halt_in=1 valid -> halt_out=1 after DEPTH advances; then flush and 5 bubbles -> halt_out remains 1; assert nRST=0 mid-clock -> all outputs zero immediately.
- With PIPE_STAGE_PERF_EN: 10 advances (2 flushed), 3 stall cycles -> stall_cnt=3, bubble_cnt=2 plus initial bubbles per DEPTH, retire_cnt=8 minus (DEPTH-1), all counters unchanged after halt.

Source files
------------

// File: rtl/pipe_stage_gen.sv
// pipe_stage_gen: parametrised pipeline latch carrying {valid, data, dREN,
// dWEN, halt} through DEPTH register stages, with stall, flush/bubble
// insertion, dhit request retirement and a sticky halt flag.
// Optional build macro PIPE_STAGE_PERF_EN adds stall/bubble/retire counters.
//
// Slot handshake: valid_in marks the incoming slot as a real instruction and
// is sampled only on an edge where stage 0 loads (ihit & (~stall | flush)).
// There is no ready; the hazard unit holds its inputs (including flush) until
// ihit arrives. valid_out marks the last stage as a real instruction.
module pipe_stage_gen #(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              dREN_in,
  input  logic              dWEN_in,
  input  logic              halt_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic              dREN_out,
  output logic              dWEN_out,
  output logic              halt_out
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       retire_cnt
`endif
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              dRen;
    logic              dWen;
    logic              halt;
  } slot_t;

  localparam int    SLOT_W = $bits(slot_t);
  localparam int    LAST   = DEPTH - 1;
  localparam slot_t BUBBLE = '{valid: 1'b0, data: RESET_VAL, dRen: 1'b0,
                               dWen: 1'b0, halt: 1'b0};

  logic                    advance;
  logic                    load0;
  slot_t                   inSlot;
  slot_t                   lastQ;
  slot_t                   lastD;
  logic [DEPTH*SLOT_W-1:0] stageBus;
  logic                    haltStickyQ;

  assign advance = ihit & ~stall;
  // Flush beats stall for stage 0 only, and only once ihit is present.
  assign load0   = ihit & (~stall | flush);
  // An invalid incoming slot is always turned into a clean bubble.
  assign inSlot  = (flush || !valid_in) ? BUBBLE
                 : slot_t'{valid: 1'b1, data: data_in, dRen: dREN_in,
                           dWen: dWEN_in, halt: halt_in};

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    localparam bit IS_LAST = (k == LAST);
    slot_t q;
    slot_t d;
    slot_t src;
    logic  load;

    if (k == 0) begin : g_head
      assign src  = inSlot;
      assign load = load0;
    end else begin : g_body
      assign src  = stageBus[(k-1)*SLOT_W +: SLOT_W];
      assign load = advance;
    end

    // Next slot: hold by default; dhit without advance retires the last
    // stage's memory requests; a load (shift or bubble) overrides both.
    always_comb begin
      d = q;
      if (IS_LAST && dhit && !advance) begin
        d.dRen = 1'b0;
        d.dWen = 1'b0;
      end
      if (load) begin
        d = src;
      end
    end

    // Stage register; reset discards contents outright.
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        q <= BUBBLE;
      end else begin
        q <= d;
      end
    end

    assign stageBus[k*SLOT_W +: SLOT_W] = q;

    if (IS_LAST) begin : g_last
      assign lastD = d;
    end
  end

  assign lastQ = stageBus[LAST*SLOT_W +: SLOT_W];

  // Sticky halt: set in step with a valid halting slot entering the last
  // stage, cleared only by reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      haltStickyQ <= 1'b0;
    end else if (lastD.valid && lastD.halt) begin
      haltStickyQ <= 1'b1;
    end
  end

  assign valid_out = lastQ.valid;
  assign data_out  = lastQ.data;
  assign dREN_out  = lastQ.dRen;
  assign dWEN_out  = lastQ.dWen;
  assign halt_out  = haltStickyQ;

`ifdef PIPE_STAGE_PERF_EN
  logic lastLoad;
  // With a single stage the last stage is stage 0 and also loads on flush.
  assign lastLoad = (LAST == 0) ? load0 : advance;

  // Performance counters; frozen once the pipe has halted.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      retire_cnt <= '0;
    end else if (!haltStickyQ) begin
      if (ihit && stall) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (lastLoad && !lastD.valid) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
      if (advance && lastQ.valid) begin
        retire_cnt <= retire_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_gen.sv
// tb_pipe_stage_gen: directed bench for pipe_stage_gen. Three instances
// (DEPTH 1, 2, 3) share one set of inputs; each step checks the instance
// that the step is about against hand-computed values.
module tb_pipe_stage_gen;

  logic        CLK      = 1'b0;
  logic        nRST     = 1'b1;
  logic        ihit     = 1'b0;
  logic        dhit     = 1'b0;
  logic        stall    = 1'b0;
  logic        flush    = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] data_in  = '0;
  logic        dREN_in  = 1'b0;
  logic        dWEN_in  = 1'b0;
  logic        halt_in  = 1'b0;

  logic        v1, r1, w1, h1;
  logic [31:0] d1;
  logic        v2, r2, w2, h2;
  logic [31:0] d2;
  logic        v3, r3, w3, h3;
  logic [31:0] d3;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] sc1, bc1, rc1, sc2, bc2, rc2, sc3, bc3, rc3;
`endif

  localparam logic [31:0] RV2 = 32'h5A5A_0000;

  int total = 0;
  int bad   = 0;

  // clock / reset
  always #5 CLK = ~CLK;

  pipe_stage_gen #(.DATA_W(32), .DEPTH(1)) u1 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .stall(stall),
    .flush(flush), .valid_in(valid_in), .data_in(data_in), .dREN_in(dREN_in),
    .dWEN_in(dWEN_in), .halt_in(halt_in), .valid_out(v1), .data_out(d1),
    .dREN_out(r1), .dWEN_out(w1), .halt_out(h1)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(sc1), .bubble_cnt(bc1), .retire_cnt(rc1)
`endif
  );

  pipe_stage_gen #(.DATA_W(32), .DEPTH(2), .RESET_VAL(RV2)) u2 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .stall(stall),
    .flush(flush), .valid_in(valid_in), .data_in(data_in), .dREN_in(dREN_in),
    .dWEN_in(dWEN_in), .halt_in(halt_in), .valid_out(v2), .data_out(d2),
    .dREN_out(r2), .dWEN_out(w2), .halt_out(h2)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(sc2), .bubble_cnt(bc2), .retire_cnt(rc2)
`endif
  );

  pipe_stage_gen #(.DATA_W(32), .DEPTH(3)) u3 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .stall(stall),
    .flush(flush), .valid_in(valid_in), .data_in(data_in), .dREN_in(dREN_in),
    .dWEN_in(dWEN_in), .halt_in(halt_in), .valid_out(v3), .data_out(d3),
    .dREN_out(r3), .dWEN_out(w3), .halt_out(h3)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(sc3), .bubble_cnt(bc3), .retire_cnt(rc3)
`endif
  );

  // scoreboard checks
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic chkb(input string tag, input logic got, input logic want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, got, want);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clearInputs();
    ihit = 1'b0; dhit = 1'b0; stall = 1'b0; flush = 1'b0;
    valid_in = 1'b0; data_in = '0; dREN_in = 1'b0; dWEN_in = 1'b0;
    halt_in = 1'b0;
  endtask

  // Short reset pulse placed mid-cycle, well clear of the next edge.
  task automatic pulseReset();
    clearInputs();
    nRST = 1'b0;
    #2;
    nRST = 1'b1;
  endtask

  initial begin
    // reset state
    #2 nRST = 1'b0;
    #2;
    chkb("rst_valid1", v1, 1'b0);
    chk ("rst_data1",  d1, 32'h0);
    chkb("rst_dren1",  r1, 1'b0);
    chkb("rst_dwen1",  w1, 1'b0);
    chkb("rst_halt1",  h1, 1'b0);
    chk ("rst_data2",  d2, RV2);
    chkb("rst_valid3", v3, 1'b0);
    @(posedge CLK);
    #1 nRST = 1'b1;

    // DEPTH=1 basic transfer, then hold and flush without ihit
    valid_in = 1'b1; data_in = 32'hDEAD_BEEF; ihit = 1'b1;
    tick();
    chkb("d1_valid", v1, 1'b1);
    chk ("d1_data",  d1, 32'hDEAD_BEEF);
    ihit = 1'b0; data_in = 32'h1111_1111; flush = 1'b1;
    tick();
    chkb("d1_hold_valid", v1, 1'b1);
    chk ("d1_flush_noihit", d1, 32'hDEAD_BEEF);

    // DEPTH=1 dhit retirement, then dhit together with ihit
    pulseReset();
    valid_in = 1'b1; data_in = 32'h55; dREN_in = 1'b1; ihit = 1'b1;
    tick();
    chkb("dh_dren_set", r1, 1'b1);
    chk ("dh_data_set", d1, 32'h55);
    ihit = 1'b0; dhit = 1'b1; data_in = 32'h66; dREN_in = 1'b0;
    tick();
    chkb("dh_dren_clr", r1, 1'b0);
    chk ("dh_data_keep", d1, 32'h55);
    chkb("dh_valid_keep", v1, 1'b1);
    ihit = 1'b1; dhit = 1'b1; data_in = 32'h77; dREN_in = 1'b1; dWEN_in = 1'b1;
    tick();
    chk ("dh_adv_data", d1, 32'h77);
    chkb("dh_adv_dren", r1, 1'b1);
    chkb("dh_adv_dwen", w1, 1'b1);

    // DEPTH=3 latency with a four-cycle stall after the second value
    pulseReset();
    ihit = 1'b1; valid_in = 1'b1; data_in = 32'd1;
    tick();
    data_in = 32'd2;
    tick();
    stall = 1'b1; data_in = 32'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      chkb("st_frozen_v3", v3, 1'b0);
      chk ("st_frozen_d3", d3, 32'h0);
      chk ("st_frozen_d2", d2, 32'd1);
      chk ("st_frozen_d1", d1, 32'd2);
    end
    stall = 1'b0;
    tick();
    chkb("st_out1_valid", v3, 1'b1);
    chk ("st_out1", d3, 32'd1);
    valid_in = 1'b0;
    tick();
    chk ("st_out2", d3, 32'd2);
    tick();
    chk ("st_out3", d3, 32'd3);
    tick();
    chkb("st_drain_valid", v3, 1'b0);
    chk ("st_drain_data", d3, 32'h0);

    // DEPTH=2 flush under stall: stage 0 bubbles, stage 1 holds
    pulseReset();
    ihit = 1'b1; valid_in = 1'b1; data_in = 32'hAAAA_0001;
    tick();
    data_in = 32'hAAAA_0002;
    tick();
    chkb("fl_pre_valid", v2, 1'b1);
    chk ("fl_pre_data", d2, 32'hAAAA_0001);
    flush = 1'b1; stall = 1'b1; data_in = 32'hAAAA_0003;
    tick();
    chkb("fl_hold_valid", v2, 1'b1);
    chk ("fl_hold_data", d2, 32'hAAAA_0001);
    flush = 1'b0; stall = 1'b0; valid_in = 1'b0;
    tick();
    chkb("fl_bub_valid", v2, 1'b0);
    chk ("fl_bub_data", d2, RV2);
    tick();
    chk ("fl_bub_data2", d2, RV2);

    // invalid slot forced to bubble; sticky halt; mid-cycle reset
    pulseReset();
    ihit = 1'b1; valid_in = 1'b0; halt_in = 1'b1; dREN_in = 1'b1; data_in = 32'h99;
    tick();
    chkb("inv_halt1", h1, 1'b0);
    chkb("inv_dren1", r1, 1'b0);
    chk ("inv_data1", d1, 32'h0);
    valid_in = 1'b1; halt_in = 1'b1; dREN_in = 1'b0; data_in = 32'h48;
    tick();
    chkb("ht_d1_set", h1, 1'b1);
    chkb("ht_d2_early", h2, 1'b0);
    valid_in = 1'b0; halt_in = 1'b0;
    tick();
    chkb("ht_d2_set", h2, 1'b1);
    chkb("ht_d2_valid", v2, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chkb("ht_sticky", h2, 1'b1);
    chkb("ht_drained", v2, 1'b0);
    #2 nRST = 1'b0;
    #1;
    chkb("mr_halt2", h2, 1'b0);
    chkb("mr_valid2", v2, 1'b0);
    chk ("mr_data2", d2, RV2);
    chkb("mr_halt1", h1, 1'b0);
    chk ("mr_data1", d1, 32'h0);
    nRST = 1'b1;
    clearInputs();

`ifdef PIPE_STAGE_PERF_EN
    // DEPTH=1 counters: 10 advances (4th and 10th flushed), 3 stall cycles
    tick();
    ihit = 1'b1; valid_in = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      data_in = i;
      flush = (i == 4 || i == 10);
      tick();
      if (i == 5) begin
        flush = 1'b0; stall = 1'b1;
        for (int j = 0; j < 3; j++) tick();
        stall = 1'b0;
      end
    end
    flush = 1'b0;
    chk("pf_stall", sc1, 32'd3);
    chk("pf_bubble", bc1, 32'd2);
    chk("pf_retire", rc1, 32'd8);
    halt_in = 1'b1;
    tick();
    halt_in = 1'b0; valid_in = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) tick();
    stall = 1'b0;
    chkb("pf_halted", h1, 1'b1);
    chk("pf_stall_frz", sc1, 32'd3);
    chk("pf_bubble_frz", bc1, 32'd2);
    chk("pf_retire_frz", rc1, 32'd8);
`endif

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
